writeback_merge_unit: RTL and testbench

WRITEBACK_MERGE_UNIT -- requirements
Module: writeback_merge_unit

---
 rtl/writeback_merge_unit_if.sv | 43 ++++
 rtl/writeback_merge_unit.sv | 116 +++++++++++
 tb/tb_writeback_merge_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/writeback_merge_unit_if.sv
// Bundle for the writeback merge unit: pipeline WB slot, late-result queue
// push side, decode hazard query, and the register file write port.
interface writeback_merge_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;
    logic              pipe_data_sel;
    logic [DATA_W-1:0] AO;
    logic [DATA_W-1:0] MO;
    logic [2:0]        load_ext;
    logic [1:0]        byte_off;
    logic              late_valid;
    logic [ADDR_W-1:0] late_addr;
    logic [DATA_W-1:0] late_data;
    logic              late_ready;
    logic [ADDR_W-1:0] query_rs;
    logic [ADDR_W-1:0] query_rt;
    logic              pending_hit;
    logic              pipe_stall;
    logic              GRF_write_enable;
    logic [ADDR_W-1:0] GRF_write_addr;
    logic [DATA_W-1:0] GRF_write_data;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  pipe_valid, pipe_addr, pipe_data_sel, AO, MO, load_ext, byte_off,
        input  late_valid, late_addr, late_data, query_rs, query_rt,
        output late_ready, pending_hit, pipe_stall,
        output GRF_write_enable, GRF_write_addr, GRF_write_data, fifo_count
    );

    modport master (
        output pipe_valid, pipe_addr, pipe_data_sel, AO, MO, load_ext, byte_off,
        output late_valid, late_addr, late_data, query_rs, query_rt,
        input  late_ready, pending_hit, pipe_stall,
        input  GRF_write_enable, GRF_write_addr, GRF_write_data, fifo_count
    );
endinterface

// File: rtl/writeback_merge_unit.sv
// Merges the in-order WB slot with a FIFO of late multi-cycle results onto a
// single register file write port; the queue head is forced after MAX_WAIT.
module writeback_merge_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    writeback_merge_unit_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, ent_off;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] mo_ext, cand_data;
    logic              cand, forced, q_nonempty, pipe_win, push, pop, hit;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] rs,
                                      input logic [ADDR_W-1:0] rt);
        return (a != '0) && ((a == rs) || (a == rt));
    endfunction

    always_comb begin
        ld_byte = bus.MO[8*bus.byte_off +: 8];
        ld_half = bus.MO[16*bus.byte_off[1] +: 16];
        case (bus.load_ext)
            3'b001:  mo_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b010:  mo_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b011:  mo_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b100:  mo_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: mo_ext = bus.MO;
        endcase
        cand_data = bus.pipe_data_sel ? mo_ext : bus.AO;
    end

    // Reset masks the queue so nothing queued is ever committed while it is being flushed.
    always_comb begin
        cand       = bus.pipe_valid && (bus.pipe_addr != '0);
        forced     = (wait_q == WAIT_W'(MAX_WAIT));
        q_nonempty = !reset && (count_q != '0);
        pipe_win   = cand && !forced;
        pop        = !pipe_win && q_nonempty;

        bus.late_ready = reset || (count_q != CNT_W'(DEPTH));
        push           = bus.late_valid && bus.late_ready && (bus.late_addr != '0);
        bus.pipe_stall = !reset && forced && cand;
        bus.fifo_count = count_q;

        bus.GRF_write_enable = pipe_win || pop;
        bus.GRF_write_addr   = '0;
        bus.GRF_write_data   = '0;
        if (pipe_win) begin
            bus.GRF_write_addr = bus.pipe_addr;
            bus.GRF_write_data = cand_data;
        end else if (pop) begin
            bus.GRF_write_addr = addr_mem_q[rd_ptr_q];
            bus.GRF_write_data = data_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        ent_off = '0;
        hit     = bus.late_valid && addr_hit(bus.late_addr, bus.query_rs, bus.query_rt);
        for (int i = 0; i < DEPTH; i++) begin
            ent_off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, ent_off} < count_q) && addr_hit(addr_mem_q[i], bus.query_rs, bus.query_rt))
                hit = 1'b1;
        end
        bus.pending_hit = !reset && hit;
    end

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = bus.late_addr;
            data_mem_d[wr_ptr_q] = bus.late_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        wait_d  = ((count_q != '0) && !pop) ? wait_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end
endmodule

// File: tb/tb_writeback_merge_unit.sv
// Directed and random bench for writeback_merge_unit against a queue-based model.
module tb_writeback_merge_unit;
    localparam int DATA_W = 32, ADDR_W = 5, DEPTH = 4, MAX_WAIT = 8;

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_merge_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    writeback_merge_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT))
        dut (.clk(clk), .reset(reset), .bus(bus));

    ent_t q[$];
    int   mwait;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] mo, input logic [2:0] le,
                                              input logic [1:0] off);
        logic [DATA_W-1:0] b, h;
        b = (mo >> (8 * off)) & 32'hFF;
        h = (mo >> (16 * off[1])) & 32'hFFFF;
        case (le)
            3'd1: return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2: return b;
            3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4: return h;
            default: return mo;
        endcase
    endfunction

    function automatic bit hits(input logic [ADDR_W-1:0] a);
        return (a != 0) && (a == bus.query_rs || a == bus.query_rt);
    endfunction

    task automatic check_model();
        bit cand, forced, nonempty, we, hit;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        cand     = bus.pipe_valid && bus.pipe_addr != 0;
        forced   = (mwait == MAX_WAIT);
        nonempty = !reset && q.size() > 0;
        we = 0; ea = 0; ed = 0;
        if (cand && !forced) begin
            we = 1; ea = bus.pipe_addr;
            ed = bus.pipe_data_sel ? ext(bus.MO, bus.load_ext, bus.byte_off) : bus.AO;
        end else if (nonempty) begin
            we = 1; ea = q[0].a; ed = q[0].d;
        end
        hit = bus.late_valid && hits(bus.late_addr);
        foreach (q[i]) if (hits(q[i].a)) hit = 1;
        chk("we",    bus.GRF_write_enable, we);
        chk("waddr", bus.GRF_write_addr, ea);
        chk("wdata", bus.GRF_write_data, ed);
        chk("stall", bus.pipe_stall, !reset && forced && cand);
        chk("ready", bus.late_ready, reset || q.size() != DEPTH);
        chk("hit",   bus.pending_hit, !reset && hit);
        chk("count", bus.fifo_count, q.size());
    endtask

    task automatic model_edge();
        bit cand, forced, emp, popm, pushm;
        if (reset) begin
            q.delete();
            mwait = 0;
            return;
        end
        cand   = bus.pipe_valid && bus.pipe_addr != 0;
        forced = (mwait == MAX_WAIT);
        emp    = (q.size() == 0);
        popm   = !emp && !(cand && !forced);
        pushm  = bus.late_valid && q.size() != DEPTH && bus.late_addr != 0;
        mwait  = (!emp && !popm) ? mwait + 1 : 0;
        if (popm) void'(q.pop_front());
        if (pushm) q.push_back('{a: bus.late_addr, d: bus.late_data});
    endtask

    task automatic cyc();
        #1 check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.pipe_valid = 0; bus.pipe_addr = 0; bus.pipe_data_sel = 0;
        bus.AO = 0; bus.MO = 0; bus.load_ext = 0; bus.byte_off = 0;
        bus.late_valid = 0; bus.late_addr = 0; bus.late_data = 0;
        bus.query_rs = 0; bus.query_rt = 0;
    endtask

    task automatic pipe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ao);
        bus.pipe_valid = 1; bus.pipe_addr = a; bus.pipe_data_sel = 0; bus.AO = ao;
    endtask

    task automatic late(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.late_valid = 1; bus.late_addr = a; bus.late_data = d;
    endtask

    initial begin
        mwait = 0;
        idle();
        reset = 1;
        @(posedge clk); model_edge(); #1;
        cyc();
        #1 chk("rst_ready", bus.late_ready, 1); chk("rst_count", bus.fifo_count, 0);
        reset = 0;
        cyc();

        // Sub-word load extension
        bus.pipe_valid = 1; bus.pipe_addr = 8; bus.pipe_data_sel = 1;
        bus.load_ext = 3'b001; bus.byte_off = 2; bus.MO = 32'h0080_0000;
        #1 chk("lb_data", bus.GRF_write_data, 32'hFFFF_FF80); chk("lb_addr", bus.GRF_write_addr, 8);
        cyc();
        bus.load_ext = 3'b100; bus.MO = 32'h8001_0000;
        #1 chk("lhu_data", bus.GRF_write_data, 32'h0000_8001);
        cyc();
        idle();

        // Late result drained on an idle pipe
        late(5, 32'h1234);
        cyc();
        bus.late_valid = 0;
        #1 chk("late_we", bus.GRF_write_enable, 1); chk("late_addr", bus.GRF_write_addr, 5);
        chk("late_data", bus.GRF_write_data, 32'h1234); chk("late_cnt1", bus.fifo_count, 1);
        cyc();
        #1 chk("late_cnt0", bus.fifo_count, 0);

        // Starvation forcing
        pipe(9, 32'hAAAA_0009); late(5, 32'h5555);
        cyc();
        bus.late_valid = 0;
        for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            #1;
            if (i == MAX_WAIT + 1) begin
                chk("force_stall", bus.pipe_stall, 1); chk("force_addr", bus.GRF_write_addr, 5);
            end else begin
                chk("held_addr", bus.GRF_write_addr, 9); chk("held_stall", bus.pipe_stall, 0);
            end
            cyc();
        end
        #1 chk("post_force_addr", bus.GRF_write_addr, 9);
        cyc();

        // Fill to full, then push+pop at full
        for (int i = 1; i <= DEPTH; i++) begin
            late(ADDR_W'(i), 32'h100 + i);
            cyc();
        end
        bus.late_valid = 0;
        #1 chk("full_ready", bus.late_ready, 0); chk("full_count", bus.fifo_count, DEPTH);
        cyc();
        bus.pipe_valid = 0; late(6, 32'h666);
        #1 chk("full_pop_addr", bus.GRF_write_addr, 1);
        cyc();
        bus.late_valid = 0;
        #1 chk("full_count3", bus.fifo_count, DEPTH - 1); chk("next_head", bus.GRF_write_addr, 2);
        for (int i = 0; i < DEPTH; i++) cyc();

        // Hazard query
        pipe(9, 32'h9); late(7, 32'h777);
        cyc();
        bus.late_valid = 0; bus.query_rs = 7;
        #1 chk("hit_q7", bus.pending_hit, 1);
        cyc();
        bus.query_rs = 0; late(0, 32'hDEAD);
        #1 chk("hit_zero", bus.pending_hit, 0);
        cyc();
        bus.late_valid = 0;
        #1 chk("zero_push_cnt", bus.fifo_count, 1);
        cyc();

        // Reset with queued entries
        late(10, 32'hA); cyc();
        late(11, 32'hB); cyc();
        bus.late_valid = 0;
        #1 chk("pre_rst_cnt", bus.fifo_count, 3);
        reset = 1;
        cyc();
        reset = 0; idle();
        #1 chk("rst_cnt0", bus.fifo_count, 0); chk("rst_ready1", bus.late_ready, 1);
        for (int i = 0; i < 12; i++) begin
            #1 chk("rst_no_write", bus.GRF_write_enable, 0);
            cyc();
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset              = ($urandom_range(0, 59) == 0);
            bus.pipe_valid     = ($urandom_range(0, 99) < 65);
            bus.pipe_addr      = ADDR_W'($urandom_range(0, 31));
            bus.pipe_data_sel  = 1'($urandom_range(0, 1));
            bus.AO             = $urandom;
            bus.MO             = $urandom;
            bus.load_ext       = 3'($urandom_range(0, 7));
            bus.byte_off       = 2'($urandom_range(0, 3));
            bus.late_valid     = ($urandom_range(0, 99) < 50);
            bus.late_addr      = ADDR_W'($urandom_range(0, 31));
            bus.late_data      = $urandom;
            bus.query_rs       = ADDR_W'($urandom_range(0, 31));
            bus.query_rt       = ADDR_W'($urandom_range(0, 31));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
